gf64_pow_seq: RTL and testbench



---
 rtl/gf64_pkg.sv | 20 ++
 rtl/gf64_mul.sv | 47 ++++
 rtl/gf64_pow_seq.sv | 164 ++++++++++++++++
 tb/tb_gf64_pow_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gf64_pkg.sv
// gf64_pkg: shared definitions for GF(2^6) field blocks.
//   GF64_W            - field element width (6)
//   GF64_MOD          - field modulus x^6 + x + 1 (primitive), polynomial basis
//   GF64_ONE          - multiplicative identity
//   CONST_TIME_CYCLES - RUN length of the constant-time exponentiation engine
//   state_t           - engine state encoding {IDLE, RUN, DONE}
package gf64_pkg;

    localparam int           GF64_W            = 6;
    localparam logic [6:0]   GF64_MOD          = 7'h43;
    localparam logic [5:0]   GF64_ONE          = 6'h01;
    localparam int           CONST_TIME_CYCLES = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gf64_mul.sv
// gf64_mul: combinational GF(2^6) multiplier, p = a * b mod MOD_POLY.
// Parameters:
//   MOD_POLY - 7-bit field modulus (bit 6 must be set)
// Ports:
//   a, b - field operands, polynomial basis (bit i = coefficient of alpha^i)
//   p    - reduced product
module gf64_mul
    import gf64_pkg::*;
#(
    parameter logic [6:0] MOD_POLY = GF64_MOD
) (
    input  logic [GF64_W-1:0] a,
    input  logic [GF64_W-1:0] b,
    output logic [GF64_W-1:0] p
);

    // One shifted copy of a per set bit of b; XOR-ing them gives the
    // 11-bit carry-less product.
    logic [2*GF64_W-2:0] pp [GF64_W];

    genvar gi;
    generate
        for (gi = 0; gi < GF64_W; gi++) begin : g_pp
            assign pp[gi] = b[gi] ? ((2*GF64_W-1)'(a) << gi) : '0;
        end
    endgenerate

    logic [2*GF64_W-2:0] clmul;
    logic [2*GF64_W-2:0] red;

    always_comb begin
        clmul = '0;
        for (int i = 0; i < GF64_W; i++) begin
            clmul = clmul ^ pp[i];
        end
        // Fold the high terms back from the top down; each step clears bit k
        // and can only disturb bits below it.
        red = clmul;
        for (int k = 2*GF64_W-2; k >= GF64_W; k--) begin
            if (red[k]) begin
                red = red ^ ((2*GF64_W-1)'(MOD_POLY) << (k - GF64_W));
            end
        end
        p = red[GF64_W-1:0];
    end

endmodule

// File: rtl/gf64_pow_seq.sv
// gf64_pow_seq: iterative GF(2^6) exponentiation engine, y = x^e.
// Left-to-right square-and-multiply over one shared gf64_mul instance.
// Build option: define CONST_TIME_EN for the constant-time variant (fixed
// 12-cycle RUN with dummy multiplies for zero exponent bits). Without it the
// multiply phase is skipped for zero bits and latency is 6 + popcount(e).
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   in_valid/in_ready- request handshake; x and e sampled on accept
//   out_valid/out_ready - result handshake; y held until accepted
//   y                - result x^e
//   busy             - high in RUN or DONE
module gf64_pow_seq
    import gf64_pkg::*;
#(
    parameter logic [6:0] MOD_POLY = GF64_MOD,
    parameter int         EXP_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [GF64_W-1:0] x,
    input  logic [EXP_W-1:0]  e,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [GF64_W-1:0] y,
    output logic              busy
);

    state_t             state_reg, state_next;
    logic [GF64_W-1:0]  acc_reg, acc_next;
    logic [GF64_W-1:0]  x_reg, x_next;
    logic [EXP_W-1:0]   e_reg, e_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [GF64_W-1:0]  y_reg, y_next;
    logic               out_valid_reg, out_valid_next;

    // cnt[0] selects square (0) or multiply (1); cnt[3:1] walks the exponent
    // bits from the MSB down.
    logic               phase;
    logic [2:0]         bit_idx;
    logic               e_bit;
    logic [GF64_W-1:0]  mul_b;
    logic [GF64_W-1:0]  prod;

    assign phase   = cnt_reg[0];
    assign bit_idx = 3'd5 - cnt_reg[3:1];
    assign e_bit   = e_reg[bit_idx];

    // The single multiplier: (acc, acc) when squaring, (acc, x) when multiplying.
    assign mul_b = phase ? x_reg : acc_reg;

    gf64_mul #(
        .MOD_POLY (MOD_POLY)
    ) u_mul (
        .a (acc_reg),
        .b (mul_b),
        .p (prod)
    );

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign y         = y_reg;

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        x_next         = x_reg;
        e_next         = e_reg;
        cnt_next       = cnt_reg;
        y_next         = y_reg;
        out_valid_next = out_valid_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    x_next     = x;
                    e_next     = e;
                    acc_next   = GF64_ONE;
                    cnt_next   = 4'd0;
                    state_next = RUN;
                end
            end

            RUN: begin
`ifdef CONST_TIME_EN
                if (!phase) begin
                    acc_next = prod;
                    cnt_next = cnt_reg + 4'd1;
                end else begin
                    // The product is always formed; a zero bit just discards it
                    // so activity does not depend on the exponent.
                    acc_next = e_bit ? prod : acc_reg;
                    if (cnt_reg == 4'(CONST_TIME_CYCLES - 1)) begin
                        y_next         = e_bit ? prod : acc_reg;
                        out_valid_next = 1'b1;
                        cnt_next       = 4'd0;
                        state_next     = DONE;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
`else
                acc_next = prod;
                if (!phase) begin
                    if (e_bit) begin
                        cnt_next = cnt_reg + 4'd1;
                    end else if (bit_idx == 3'd0) begin
                        y_next         = prod;
                        out_valid_next = 1'b1;
                        cnt_next       = 4'd0;
                        state_next     = DONE;
                    end else begin
                        // Zero bit: jump straight to the next bit's square.
                        cnt_next = cnt_reg + 4'd2;
                    end
                end else begin
                    if (bit_idx == 3'd0) begin
                        y_next         = prod;
                        out_valid_next = 1'b1;
                        cnt_next       = 4'd0;
                        state_next     = DONE;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
`endif
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            x_reg         <= '0;
            e_reg         <= '0;
            cnt_reg       <= '0;
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            x_reg         <= x_next;
            e_reg         <= e_next;
            cnt_reg       <= cnt_next;
            y_reg         <= y_next;
            out_valid_reg <= out_valid_next;
        end
    end

endmodule

// File: tb/tb_gf64_pow_seq.sv
module tb_gf64_pow_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] x;
    logic [5:0] e;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] y;
    logic       busy;

    int n_checks;
    int n_pass;

    gf64_pow_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .e         (e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: multiply by shift-and-add with alpha^6 = alpha + 1,
    // power by repeated multiplication.
    function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p;
        logic [5:0] aa;
        p  = 6'h00;
        aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[4:0], 1'b0} ^ (aa[5] ? 6'h03 : 6'h00);
        end
        return p;
    endfunction

    function automatic logic [5:0] ref_pow(input logic [5:0] xv, input logic [5:0] ev);
        logic [5:0] r;
        r = 6'h01;
        for (int i = 0; i < int'(ev); i++) r = ref_mul(r, xv);
        return r;
    endfunction

    function automatic int exp_lat(input logic [5:0] ev);
`ifdef CONST_TIME_EN
        return 12;
`else
        return 6 + $countones(ev);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return just after the accept edge.
    task automatic start_op(input logic [5:0] xv, input logic [5:0] ev);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        x        = xv;
        e        = ev;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input logic [5:0] xv, input logic [5:0] ev, input logic [5:0] expy);
        int lat;
        start_op(xv, ev);
        check("busy_run", 32'(busy), 32'd1);
        check("in_ready_run", 32'(in_ready), 32'd0);
        wait_done(lat);
        $display("op x=%02h e=%0d y=%02h lat=%0d", xv, ev, y, lat);
        check("y", 32'(y), 32'(expy));
        check("latency", 32'(lat), 32'(exp_lat(ev)));
        tick();
        check("out_valid_pulse", 32'(out_valid), 32'd0);
        check("in_ready_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [5:0] held_y;

        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = 6'h00;
        e         = 6'h00;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic power, inversion, identity, zero cases
        do_op(6'h02, 6'd17, 6'h26);
        do_op(6'h02, 6'd62, 6'h21);
        do_op(6'h02, 6'd63, 6'h01);
        do_op(6'h2B, 6'd1,  6'h2B);
        do_op(6'h00, 6'd0,  6'h01);
        do_op(6'h00, 6'd17, 6'h00);
        do_op(6'h3F, 6'd0,  6'h01);
        do_op(6'h00, 6'd62, 6'h00);

        // Backpressure: result held, second request ignored
        out_ready = 1'b0;
        start_op(6'h02, 6'd17);
        wait_done(lat);
        $display("op x=02 e=17 y=%02h lat=%0d (held)", y, lat);
        check("bp_y", 32'(y), 32'h26);
        check("bp_latency", 32'(lat), 32'(exp_lat(6'd17)));
        held_y   = y;
        in_valid = 1'b1;
        x        = 6'h05;
        e        = 6'd3;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_hold_y", 32'(y), 32'(held_y));
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_busy", 32'(busy), 32'd0);

        // Reset in the middle of RUN
        start_op(6'h02, 6'd63);
        repeat (4) tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("abort_no_output", 32'(seen), 32'd0);
        $display("op reset mid-run, out_valid cycles=%0d", seen);
        do_op(6'h02, 6'd6, 6'h03);

        // Exhaustive sweep against the reference model
        for (int ei = 0; ei < 64; ei++) begin
            for (int xi = 0; xi < 64; xi++) begin
                do_op(6'(xi), 6'(ei), ref_pow(6'(xi), 6'(ei)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
